fmc_apb_bridge: RTL and testbench



---
 rtl/fmc_apb_pkg.sv | 18 +
 rtl/apb_if.sv | 30 +++
 rtl/fmc_input_sync.sv | 34 +++
 rtl/fmc_apb_bridge.sv | 197 +++++++++++++++++++
 tb/tb_fmc_apb_bridge.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fmc_apb_pkg.sv
// rtl/fmc_apb_pkg.sv - shared types and constants for fmc_apb_bridge
//   state_e     : bridge FSM states
//   RD_ERR_DATA : read data returned when the completer errors or times out
//   HW_SEL_BIT  : FMC byte-address bit that selects the low/high halfword
package fmc_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SETUP,
    ACCESS,
    HOLD
  } state_e;

  localparam logic [31:0] RD_ERR_DATA = 32'hffff_ffff;
  localparam int unsigned HW_SEL_BIT  = 1;

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - APB bus bundle with requester and completer views
//   DATA_WIDTH, ADDR_WIDTH : bus widths
//   requester : drives clock/reset passthrough, select, enable, address, write data, strobes
//   completer : drives read data, ready, slave error
interface APB #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                    pclk;
  logic                    preset_n;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport requester (
    output pclk, preset_n, psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport completer (
    input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/fmc_input_sync.sv
// rtl/fmc_input_sync.sv - multi-bit flop-chain synchronizer for the FMC pads
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : raw pad vector
//   q          : vector after STAGES flops; every bit sees the same latency
//   RST_VAL    : per-bit reset value (strobes reset high, others low)
module fmc_input_sync #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       STAGES  = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {STAGES{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fmc_apb_bridge.sv
// rtl/fmc_apb_bridge.sv - FMC 16-bit async NOR/SRAM bus to 32-bit APB requester
//   pclk, preset_n          : clock and asynchronous active-low reset (forwarded on apb)
//   fmc_ne_n/noe_n/nwe_n    : FMC chip select, read and write strobes
//   fmc_a, fmc_ad_in        : FMC byte address and pad data in
//   fmc_ad_out, fmc_ad_oe   : pad data out and its output enable
//   fmc_nwait               : active-low stall to the MCU
//   err                     : one-cycle pulse on PSLVERR (or timeout)
//   apb                     : APB requester port
// Optional build macro FMC_APB_BRIDGE_TIMEOUT_EN adds the ACCESS timeout counter.
module fmc_apb_bridge
  import fmc_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  fmc_ne_n,
  input  logic                  fmc_noe_n,
  input  logic                  fmc_nwe_n,
  input  logic [ADDR_WIDTH-1:0] fmc_a,
  input  logic [15:0]           fmc_ad_in,
  output logic [15:0]           fmc_ad_out,
  output logic                  fmc_ad_oe,
  output logic                  fmc_nwait,
  output logic                  err,
  APB.requester                 apb
);

  localparam int unsigned SW = 3 + ADDR_WIDTH + 16;

  logic [SW-1:0]         sync_q;
  logic                  ne_s, noe_s, nwe_s;
  logic [ADDR_WIDTH-1:0] a_s;
  logic [15:0]           ad_s;

  // Address and data ride the same chain as the strobes so they stay aligned.
  fmc_input_sync #(
    .WIDTH   (SW),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({3'b111, {(ADDR_WIDTH + 16){1'b0}}})
  ) u_sync (
    .clk   (pclk),
    .rst_n (preset_n),
    .d     ({fmc_ne_n, fmc_noe_n, fmc_nwe_n, fmc_a, fmc_ad_in}),
    .q     (sync_q)
  );

  assign {ne_s, noe_s, nwe_s, a_s, ad_s} = sync_q;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           din_q, din_d, wr_lo_q, wr_lo_d, ad_out_q, ad_out_d;
  logic                  wr_q, wr_d, pwrite_q, pwrite_d, err_q, err_d;
  logic [31:0]           rd_buf_q, rd_buf_d, pwdata_q, pwdata_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  strobe, hw_hi, needs_apb, timeout, xfer_done, xfer_err;
  logic                  psel_c, penable_c, nwait_c, ad_oe_c;
  logic                  unused_addr0;

  assign strobe       = !ne_s && (!noe_s || !nwe_s);
  assign hw_hi        = addr_q[HW_SEL_BIT];
  // Low-half writes and high-half reads are served locally from wr_lo/rd_buf.
  assign needs_apb    = wr_q ? hw_hi : !hw_hi;
  assign unused_addr0 = addr_q[0];

`ifdef FMC_APB_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts completed ACCESS cycles, so TIMEOUT_CYCLES-1 marks the last allowed one.
  assign timeout = (state_q == ACCESS) && !apb.pready && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = (state_q == ACCESS) ? cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) cnt_q <= 8'd0;
    else           cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign xfer_done = (state_q == ACCESS) && (apb.pready || timeout);
  assign xfer_err  = (state_q == ACCESS) && ((apb.pready && apb.pslverr) || timeout);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (strobe) state_d = DECODE;
      DECODE:  state_d = needs_apb ? SETUP : HOLD;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = HOLD;
      HOLD:    if (ne_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_c    = 1'b0;
    penable_c = 1'b0;
    nwait_c   = 1'b1;
    ad_oe_c   = 1'b0;
    case (state_q)
      DECODE:  nwait_c = 1'b0;
      SETUP:   begin psel_c = 1'b1; nwait_c = 1'b0; end
      ACCESS:  begin psel_c = 1'b1; penable_c = 1'b1; nwait_c = 1'b0; end
      // Drive the pad only while the MCU still holds NE; an aborted read never drives.
      HOLD:    ad_oe_c = !wr_q && !ne_s;
      default: ;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    din_d    = din_q;
    wr_d     = wr_q;
    wr_lo_d  = wr_lo_q;
    rd_buf_d = rd_buf_q;
    ad_out_d = ad_out_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (strobe) begin
        addr_d = a_s;
        din_d  = ad_s;
        wr_d   = !nwe_s;
      end
      DECODE: begin
        if (wr_q && !hw_hi)  wr_lo_d  = din_q;
        if (!wr_q && hw_hi)  ad_out_d = rd_buf_q[31:16];
        if (needs_apb) begin
          paddr_d  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
          pwrite_d = wr_q;
          pwdata_d = {din_q, wr_lo_q};
        end
      end
      ACCESS: if (xfer_done) begin
        err_d = xfer_err;
        if (!wr_q) begin
          rd_buf_d = xfer_err ? RD_ERR_DATA : apb.prdata;
          ad_out_d = xfer_err ? RD_ERR_DATA[15:0] : apb.prdata[15:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      addr_q   <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      wr_lo_q  <= '0;
      rd_buf_q <= '0;
      ad_out_q <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      din_q    <= din_d;
      wr_q     <= wr_d;
      wr_lo_q  <= wr_lo_d;
      rd_buf_q <= rd_buf_d;
      ad_out_q <= ad_out_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      err_q    <= err_d;
    end
  end

  assign fmc_ad_out   = ad_out_q;
  assign fmc_ad_oe    = ad_oe_c;
  assign fmc_nwait    = nwait_c;
  assign err          = err_q;
  assign apb.pclk     = pclk;
  assign apb.preset_n = preset_n;
  assign apb.psel     = psel_c;
  assign apb.penable  = penable_c;
  assign apb.pwrite   = pwrite_q;
  assign apb.paddr    = paddr_q;
  assign apb.pwdata   = pwdata_q;
  assign apb.pstrb    = 4'hf;

endmodule

// File: tb/tb_fmc_apb_bridge.sv
// tb/tb_fmc_apb_bridge.sv - self-checking bench for fmc_apb_bridge
module tb_fmc_apb_bridge;

  localparam int AW = 12;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic          fmc_ne_n = 1'b1, fmc_noe_n = 1'b1, fmc_nwe_n = 1'b1;
  logic [AW-1:0] fmc_a = '0;
  logic [15:0]   fmc_ad_in = '0;
  logic [15:0]   fmc_ad_out;
  logic          fmc_ad_oe, fmc_nwait, err;

  APB #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) apb ();

  fmc_apb_bridge #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(255)) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .fmc_ne_n   (fmc_ne_n),
    .fmc_noe_n  (fmc_noe_n),
    .fmc_nwe_n  (fmc_nwe_n),
    .fmc_a      (fmc_a),
    .fmc_ad_in  (fmc_ad_in),
    .fmc_ad_out (fmc_ad_out),
    .fmc_ad_oe  (fmc_ad_oe),
    .fmc_nwait  (fmc_nwait),
    .err        (err),
    .apb        (apb)
  );

  always #5 pclk = ~pclk;

  int n_assert = 0;
  int n_fail   = 0;

  // APB completer: cfg_waits wait states, then ready with the configured data/error.
  int          cfg_waits = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  int          wcnt      = 0;

  initial begin
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (apb.psel && apb.penable && !apb.pready) begin
        if (wcnt >= cfg_waits) begin
          apb.pready  = 1'b1;
          apb.prdata  = cfg_rdata;
          apb.pslverr = cfg_err;
        end else begin
          wcnt++;
        end
      end else begin
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        wcnt        = 0;
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  int            n_txn = 0, access_cyc = 0, nwait_low = 0, err_cyc = 0;
  logic [AW-1:0] txn_addr = '0;
  logic          txn_write = 1'b0;
  logic [31:0]   txn_wdata = '0;
  logic [3:0]    txn_strb = '0;

  always @(negedge pclk) begin
    if (apb.psel && apb.penable) access_cyc++;
    if (apb.psel && apb.penable && apb.pready) begin
      n_txn++;
      txn_addr  = apb.paddr;
      txn_write = apb.pwrite;
      txn_wdata = apb.pwdata;
      txn_strb  = apb.pstrb;
    end
    if (!fmc_nwait) nwait_low++;
    if (err) err_cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One FMC NOR/SRAM access as the MCU would perform it.
  task automatic fmc_access(input logic wr, input logic [AW-1:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output logic oe, output logic oe_after,
                            output logic ok);
    @(negedge pclk);
    fmc_a     = addr;
    fmc_ad_in = wd;
    fmc_ne_n  = 1'b0;
    if (wr) fmc_nwe_n = 1'b0;
    else    fmc_noe_n = 1'b0;
    repeat (6) @(negedge pclk);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (fmc_nwait) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    rd = fmc_ad_out;
    oe = fmc_ad_oe;
    fmc_ne_n  = 1'b1;
    fmc_noe_n = 1'b1;
    fmc_nwe_n = 1'b1;
    repeat (6) @(negedge pclk);
    oe_after = fmc_ad_oe;
  endtask

  // Reference model state.
  logic [15:0] m_wr_lo  = '0;
  logic [31:0] m_rd_buf = '0;

  task automatic run_op(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [15:0] wd, input int waits, input logic [31:0] rdat,
                        input logic perr, output logic [15:0] rd);
    int   t0, a0, w0, e0;
    logic oe, oe_after, ok, hi, apb_op;
    cfg_waits = waits;
    cfg_rdata = rdat;
    cfg_err   = perr;
    t0 = n_txn; a0 = access_cyc; w0 = nwait_low; e0 = err_cyc;
    fmc_access(wr, addr, wd, rd, oe, oe_after, ok);
    hi     = addr[1];
    apb_op = wr ? hi : !hi;
    check({tag, " nwait released"}, 32'(ok), 32'd1);
    check({tag, " apb count"}, 32'(n_txn - t0), apb_op ? 32'd1 : 32'd0);
    check({tag, " nwait low cycles"}, 32'(nwait_low - w0), apb_op ? 32'(waits + 3) : 32'd1);
    check({tag, " err cycles"}, 32'(err_cyc - e0), (apb_op && perr) ? 32'd1 : 32'd0);
    if (apb_op) begin
      check({tag, " access cycles"}, 32'(access_cyc - a0), 32'(waits + 1));
      check({tag, " paddr"}, 32'(txn_addr), 32'({addr[AW-1:2], 2'b00}));
      check({tag, " pwrite"}, 32'(txn_write), 32'(wr));
      check({tag, " pstrb"}, 32'(txn_strb), 32'hf);
      if (wr) check({tag, " pwdata"}, txn_wdata, {wd, m_wr_lo});
    end
    if (wr && !hi)  m_wr_lo  = wd;
    if (!wr && !hi) m_rd_buf = perr ? 32'hffff_ffff : rdat;
    if (!wr) begin
      check({tag, " oe"}, 32'(oe), 32'd1);
      check({tag, " rdata"}, 32'(rd), 32'(hi ? m_rd_buf[31:16] : m_rd_buf[15:0]));
    end
    check({tag, " oe after NE"}, 32'(oe_after), 32'd0);
  endtask

  initial begin
    logic [15:0]   rd;
    logic          oe, oe_after, ok;
    logic [AW-1:0] ra;
    int            e0, a0;

    #3;
    check("reset psel", 32'(apb.psel), 32'd0);
    check("reset nwait", 32'(fmc_nwait), 32'd1);
    check("reset pstrb", 32'(apb.pstrb), 32'hf);
    check("reset oe", 32'(fmc_ad_oe), 32'd0);
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);

    run_op("wr lo C04", 1'b1, 12'hC04, 16'h1234, 0, 32'h0, 1'b0, rd);
    run_op("wr hi C06", 1'b1, 12'hC06, 16'h5678, 1, 32'h0, 1'b0, rd);
    check("wr pair pwdata", txn_wdata, 32'h5678_1234);
    check("wr pair paddr", 32'(txn_addr), 32'hC04);

    run_op("rd lo 800", 1'b0, 12'h800, 16'h0, 3, 32'hCAFE_BABE, 1'b0, rd);
    check("rd lo 800 pad", 32'(rd), 32'hBABE);
    run_op("rd hi 802", 1'b0, 12'h802, 16'h0, 0, 32'h0, 1'b0, rd);
    check("rd hi 802 pad", 32'(rd), 32'hCAFE);

    run_op("err rd 000", 1'b0, 12'h000, 16'h0, 1, 32'h1357_2468, 1'b1, rd);
    check("err rd 000 pad", 32'(rd), 32'hFFFF);
    run_op("err rd 002", 1'b0, 12'h002, 16'h0, 0, 32'h0, 1'b0, rd);
    check("err rd 002 pad", 32'(rd), 32'hFFFF);

`ifdef FMC_APB_BRIDGE_TIMEOUT_EN
    cfg_waits = 100000;
    e0 = err_cyc; a0 = access_cyc;
    fmc_access(1'b0, 12'h100, 16'h0, rd, oe, oe_after, ok);
    check("timeout nwait released", 32'(ok), 32'd1);
    check("timeout access cycles", 32'(access_cyc - a0), 32'd255);
    check("timeout rdata", 32'(rd), 32'hFFFF);
    check("timeout err cycles", 32'(err_cyc - e0), 32'd1);
    check("timeout oe after NE", 32'(oe_after), 32'd0);
    m_rd_buf = 32'hffff_ffff;
`endif

    for (int i = 0; i < 24; i++) begin
      ra = 12'($urandom);
      run_op($sformatf("rand%0d", i), 1'($urandom), ra, 16'($urandom),
             int'($urandom_range(0, 4)), $urandom, ($urandom_range(0, 7) == 0), rd);
    end

    // Asynchronous reset in the middle of a stalled high-half write.
    cfg_waits = 100000;
    @(negedge pclk);
    fmc_a = 12'hFFE; fmc_ad_in = 16'h5A5A; fmc_ne_n = 1'b0; fmc_nwe_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (apb.psel && apb.penable) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall reached access", 32'(ok), 32'd1);
    check("stall pwdata", apb.pwdata, {16'h5A5A, m_wr_lo});
`ifndef FMC_APB_BRIDGE_TIMEOUT_EN
    repeat (300) @(negedge pclk);
    check("no timeout psel", 32'(apb.psel), 32'd1);
    check("no timeout penable", 32'(apb.penable), 32'd1);
`endif
    #2 preset_n = 1'b0;
    #1;
    check("async rst psel", 32'(apb.psel), 32'd0);
    check("async rst penable", 32'(apb.penable), 32'd0);
    check("async rst pwrite", 32'(apb.pwrite), 32'd0);
    check("async rst paddr", 32'(apb.paddr), 32'd0);
    check("async rst pwdata", apb.pwdata, 32'd0);
    check("async rst pstrb", 32'(apb.pstrb), 32'hf);
    check("async rst nwait", 32'(fmc_nwait), 32'd1);
    check("async rst oe", 32'(fmc_ad_oe), 32'd0);
    check("async rst ad_out", 32'(fmc_ad_out), 32'd0);
    check("async rst err", 32'(err), 32'd0);
    check("async rst apb.preset_n", 32'(apb.preset_n), 32'd0);
    fmc_ne_n = 1'b1; fmc_nwe_n = 1'b1;
    m_wr_lo = '0; m_rd_buf = '0;
    cfg_waits = 0;
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);

    run_op("post rst wr lo", 1'b1, 12'h010, 16'h00AA, 0, 32'h0, 1'b0, rd);
    run_op("post rst wr hi", 1'b1, 12'h012, 16'h00BB, 2, 32'h0, 1'b0, rd);
    check("post rst pwdata", txn_wdata, 32'h00BB_00AA);
    run_op("post rst rd hi", 1'b0, 12'h006, 16'h0, 0, 32'h0, 1'b0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
